// File: rtl/ascon_pkg.sv
// Shared types and helpers for the ASCON permutation control path.
package ascon_pkg;

  localparam int ASCON_MAX_ROUNDS = 12;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} perm_state_e;
  typedef enum logic {PERM_A, PERM_B} perm_mode_e;

  // Round constant from the remaining-round count; each nibble wraps mod 16.
  function automatic logic [7:0] round_const(input logic [3:0] cnt);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'd3 + cnt;
    lo = 4'd12 - cnt;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Request, round-strobe and completion signals between the phase FSM,
// the round scheduler and the round datapath.
interface ascon_perm_ctrl_if;

  logic       start_valid_i;
  logic       start_ready_o;
  logic       mode_i;
  logic       abort_i;
  logic       stall_i;
  logic       round_en_o;
  logic       round_last_o;
  logic [7:0] rc_o;
  logic       busy_o;
  logic       done_valid_o;
  logic       done_ready_i;

  modport slave (
    input  start_valid_i, mode_i, abort_i, stall_i, done_ready_i,
    output start_ready_o, round_en_o, round_last_o, rc_o, busy_o, done_valid_o
  );

  modport master (
    output start_valid_i, mode_i, abort_i, stall_i, done_ready_i,
    input  start_ready_o, round_en_o, round_last_o, rc_o, busy_o, done_valid_o
  );

endinterface

// File: rtl/ascon_down_counter.sv
// Loadable down counter that saturates at zero; clear beats load beats decrement.
module ascon_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  assign zero_o = (count_o == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= load_val_i;
    end else if (en_i && !zero_o) begin
      count_o <= count_o - 1'b1;
    end
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Round scheduler for the ASCON permutation: accepts p^a/p^b requests, strobes
// one round enable plus round constant per round, and hands back a done token.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int CNT_W     = 4
) (
  input logic               clk,
  input logic               rst,
  ascon_perm_ctrl_if.slave  bus
);

  perm_state_e      state;
  perm_state_e      state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;
  logic             rst_n;
  logic             accept;
  logic             round_en;
  logic             round_last;
  logic             start_ready;
  logic             done_valid;
  logic [7:0]       rc;

  assign rst_n    = ~rst;
  assign load_val = (perm_mode_e'(bus.mode_i) == PERM_B) ? CNT_W'(PB_ROUNDS)
                                                         : CNT_W'(PA_ROUNDS);

  ascon_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (bus.abort_i),
    .load_i     (accept),
    .load_val_i (load_val),
    .en_i       (round_en),
    .count_o    (count),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    start_ready = 1'b0;
    round_en    = 1'b0;
    round_last  = 1'b0;
    done_valid  = 1'b0;
    rc          = 8'h00;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid_i) begin
          accept  = 1'b1;
          state_n = ROUND;
        end
      end
      ROUND: begin
        // The zero guard only matters for an illegal zero-round load.
        round_en   = !bus.stall_i && !cnt_zero;
        round_last = (count == CNT_W'(1));
        rc         = round_const(count[3:0]);
        if (round_en && round_last) state_n = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (bus.done_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides every other event, including a pending done.
    if (bus.abort_i) begin
      state_n    = IDLE;
      accept     = 1'b0;
      round_en   = 1'b0;
      done_valid = 1'b0;
    end
  end

  assign bus.start_ready_o = start_ready;
  assign bus.round_en_o    = round_en;
  assign bus.round_last_o  = round_last;
  assign bus.rc_o          = rc;
  assign bus.busy_o        = (state != IDLE);
  assign bus.done_valid_o  = done_valid;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed self-checking bench for the ASCON round scheduler.
module tb_ascon_perm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] rc_a [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                            8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  ascon_perm_ctrl_if bus ();

  ascon_perm_ctrl #(.PA_ROUNDS(12), .PB_ROUNDS(6), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 32'(bus.start_ready_o), 1);
    check({tag, "_round_en"},    32'(bus.round_en_o),    0);
    check({tag, "_round_last"},  32'(bus.round_last_o),  0);
    check({tag, "_rc"},          32'(bus.rc_o),          0);
    check({tag, "_busy"},        32'(bus.busy_o),        0);
    check({tag, "_done_valid"},  32'(bus.done_valid_o),  0);
  endtask

  initial begin
    int c;
    int pulses;
    int done_at;
    int n;
    logic seen_done;

    bus.start_valid_i = 1'b0;
    bus.mode_i        = 1'b0;
    bus.abort_i       = 1'b0;
    bus.stall_i       = 1'b0;
    bus.done_ready_i  = 1'b0;

    // Reset values
    #2;
    check_reset_outputs("reset");
    check("reset_count", 32'(dut.u_cnt.count_o), 0);
    cyc();
    rst = 1'b0;

    // p^a without stalls: rounds on cycles 1..12, done on cycle 13
    cyc();
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b0;
    #1;
    check("pa_accept_ready", 32'(bus.start_ready_o), 1);
    cyc();
    bus.start_valid_i = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      check("pa_round_en", 32'(bus.round_en_o), 1);
      check("pa_rc", 32'(bus.rc_o), 32'(rc_a[i]));
      check("pa_round_last", 32'(bus.round_last_o), (i == 11) ? 1 : 0);
      check("pa_start_ready_busy", 32'(bus.start_ready_o), 0);
      cyc();
      #1;
    end
    check("pa_done_valid", 32'(bus.done_valid_o), 1);
    check("pa_done_round_en", 32'(bus.round_en_o), 0);
    check("pa_done_rc", 32'(bus.rc_o), 0);
    check("pa_done_busy", 32'(bus.busy_o), 1);
    bus.done_ready_i = 1'b1;
    #1;
    cyc();
    bus.done_ready_i = 1'b0;
    #1;
    check("pa_after_ack_done", 32'(bus.done_valid_o), 0);
    check("pa_after_ack_ready", 32'(bus.start_ready_o), 1);

    // p^b: constants 96..4B, done on cycle 7
    cyc();
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b1;
    #1;
    cyc();
    bus.start_valid_i = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("pb_round_en", 32'(bus.round_en_o), 1);
      check("pb_rc", 32'(bus.rc_o), 32'(rc_a[i + 6]));
      check("pb_round_last", 32'(bus.round_last_o), (i == 5) ? 1 : 0);
      cyc();
      #1;
    end
    check("pb_done_valid", 32'(bus.done_valid_o), 1);
    bus.done_ready_i = 1'b1;
    #1;
    cyc();
    bus.done_ready_i = 1'b0;

    // p^a with a two-cycle stall on round 3
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b0;
    #1;
    cyc();
    bus.start_valid_i = 1'b0;
    c       = 1;
    pulses  = 0;
    done_at = 0;
    while (c < 40 && done_at == 0) begin
      bus.stall_i = (c == 3 || c == 4);
      #1;
      if (c >= 3 && c <= 5) check("stall_rc_hold", 32'(bus.rc_o), 32'h D2);
      if (c == 3) check("stall_no_round_en", 32'(bus.round_en_o), 0);
      if (bus.done_valid_o) begin
        done_at = c;
      end else begin
        if (bus.round_en_o) pulses++;
        cyc();
        c++;
      end
    end
    bus.stall_i = 1'b0;
    check("stall_pulses", 32'(pulses), 12);
    check("stall_done_cycle", 32'(done_at), 15);

    // Done held unacknowledged while a new request waits
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_done_valid", 32'(bus.done_valid_o), 1);
      check("hold_start_ready", 32'(bus.start_ready_o), 0);
      cyc();
      #1;
    end
    bus.done_ready_i = 1'b1;
    #1;
    check("ack_cycle_start_ready", 32'(bus.start_ready_o), 0);
    cyc();
    bus.done_ready_i = 1'b0;
    #1;
    check("post_ack_idle", 32'(bus.busy_o), 0);
    check("post_ack_ready", 32'(bus.start_ready_o), 1);
    cyc();
    bus.start_valid_i = 1'b0;
    #1;
    check("post_ack_round1_en", 32'(bus.round_en_o), 1);
    check("post_ack_round1_rc", 32'(bus.rc_o), 32'h F0);

    // Abort during round 5 of that p^a
    repeat (4) cyc();
    #1;
    check("abort_round5_rc", 32'(bus.rc_o), 32'h B4);
    bus.abort_i = 1'b1;
    #1;
    check("abort_no_round_en", 32'(bus.round_en_o), 0);
    cyc();
    bus.abort_i = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy_o), 0);
    check("abort_ready", 32'(bus.start_ready_o), 1);
    check("abort_count", 32'(dut.u_cnt.count_o), 0);
    seen_done = 1'b0;
    repeat (20) begin
      if (bus.done_valid_o) seen_done = 1'b1;
      cyc();
    end
    check("abort_no_done", 32'(seen_done), 0);

    // Abort in IDLE beats a simultaneous start
    bus.abort_i       = 1'b1;
    bus.start_valid_i = 1'b1;
    #1;
    cyc();
    bus.abort_i       = 1'b0;
    bus.start_valid_i = 1'b0;
    #1;
    check("idle_abort_busy", 32'(bus.busy_o), 0);
    check("idle_abort_count", 32'(dut.u_cnt.count_o), 0);

    // Reset pulse during round 8, then a fresh p^b
    cyc();
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b0;
    #1;
    cyc();
    bus.start_valid_i = 1'b0;
    #1;
    repeat (7) cyc();
    #1;
    check("rst_round8_rc", 32'(bus.rc_o), 32'h 87);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_count", 32'(dut.u_cnt.count_o), 0);
    cyc();
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_release");
    bus.start_valid_i = 1'b1;
    bus.mode_i        = 1'b1;
    #1;
    cyc();
    bus.start_valid_i = 1'b0;
    c       = 1;
    n       = 0;
    done_at = 0;
    while (c < 30 && done_at == 0) begin
      #1;
      if (bus.done_valid_o) begin
        done_at = c;
      end else begin
        if (bus.round_en_o) begin
          if (n < 6) check("fresh_pb_rc", 32'(bus.rc_o), 32'(rc_a[n + 6]));
          n++;
        end
        cyc();
        c++;
      end
    end
    check("fresh_pb_rounds", 32'(n), 6);
    check("fresh_pb_done_cycle", 32'(done_at), 7);
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
    #1;
    check("fresh_pb_idle", 32'(bus.busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
